// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage: owns the PC, keeps one request outstanding to
// instruction memory, and drives the IF/ID register with a one-entry skid buffer.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        IMem_Req_o,
  output logic [31:0] IMem_Addr_o,
  input  logic        IMem_Ready_i,
  input  logic        IMem_Valid_i,
  input  logic [31:0] IMem_Data_i,
  input  logic        Stall_i,
  input  logic        Redirect_i,
  input  logic [31:0] Redirect_PC_i,
  output logic [31:0] Inst_o,
  output logic [31:0] PC_o,
  output logic        Valid_o
);

  typedef enum logic [1:0] {FETCH, WAIT, DROP} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] reqPc_q;
  logic [31:0] inst_q;
  logic [31:0] pcOut_q;
  logic        valid_q;
  logic [31:0] skidInst_q;
  logic [31:0] skidPc_q;
  logic        skidValid_q;

  logic        fetchReq;
  logic        accept;
  logic        consume;
  logic        respIn;
  logic        unusedRedirLsb;

  // A new request waits until the skid is empty so at most two words are ever held.
  assign fetchReq       = (state_q == FETCH) && !skidValid_q && !rst_i && !Redirect_i;
  assign accept         = fetchReq && IMem_Ready_i;
  assign consume        = valid_q && !Stall_i;
  assign respIn         = (state_q == WAIT) && IMem_Valid_i;
  assign unusedRedirLsb = ^Redirect_PC_i[1:0];

  assign IMem_Req_o  = fetchReq;
  assign IMem_Addr_o = pc_q;
  assign Inst_o      = inst_q;
  assign PC_o        = pcOut_q;
  assign Valid_o     = valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      reqPc_q     <= RESET_PC;
      inst_q      <= NOP_INST;
      pcOut_q     <= 32'h0000_0000;
      valid_q     <= 1'b0;
      skidInst_q  <= NOP_INST;
      skidPc_q    <= 32'h0000_0000;
      skidValid_q <= 1'b0;
    end else if (Redirect_i) begin
      // A response still in flight belongs to the old path; DROP swallows it.
      state_q     <= ((state_q != FETCH) && !IMem_Valid_i) ? DROP : FETCH;
      pc_q        <= {Redirect_PC_i[31:2], 2'b00};
      inst_q      <= NOP_INST;
      valid_q     <= 1'b0;
      skidValid_q <= 1'b0;
    end else begin
      if (accept) begin
        pc_q    <= pc_q + 32'd4;
        reqPc_q <= pc_q;
        state_q <= WAIT;
      end
      if ((state_q == DROP) && IMem_Valid_i) begin
        state_q <= FETCH;
      end
      if (respIn) begin
        state_q <= FETCH;
        if (!valid_q || !Stall_i) begin
          inst_q  <= IMem_Data_i;
          pcOut_q <= reqPc_q;
          valid_q <= 1'b1;
        end else begin
          skidInst_q  <= IMem_Data_i;
          skidPc_q    <= reqPc_q;
          skidValid_q <= 1'b1;
        end
      end else if (consume) begin
        if (skidValid_q) begin
          inst_q      <= skidInst_q;
          pcOut_q     <= skidPc_q;
          skidValid_q <= 1'b0;
        end else begin
          inst_q  <= NOP_INST;
          valid_q <= 1'b0;
        end
      end
    end
  end

endmodule
